// File: rtl/intc_route_sequencer_pkg.sv
// Shared types and sizing for the Benes route sequencer.
// The optional table parity check is enabled by the INTC_ROUTE_PARITY_EN macro.
package intc_route_sequencer_pkg;

  localparam int PORT_NUM        = 32;
  localparam int SWITCH_NUM      = PORT_NUM / 2;
  localparam int STAGE_NUM       = 2 * $clog2(PORT_NUM) - 1;
  localparam int CFG_DEPTH       = 16;
  localparam int TAG_WIDTH       = 4;
  localparam int INTC_LATENCY    = 11;
  localparam int MAX_INFLIGHT    = 8;
  localparam int INTC_CFG_ADDR_W = $clog2(CFG_DEPTH);
  localparam int INFLIGHT_W      = $clog2(MAX_INFLIGHT + 1);

  typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] intc_sel_t;
  typedef logic [TAG_WIDTH-1:0]                 intc_tag_t;
  typedef logic [INTC_CFG_ADDR_W-1:0]           intc_addr_t;
  typedef logic [INFLIGHT_W-1:0]                intc_count_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } intc_seq_state_t;

  localparam intc_count_t MAX_CNT = intc_count_t'(MAX_INFLIGHT);

  // Even parity: the stored bit makes the XOR of the whole entry zero.
  function automatic logic route_parity(input intc_sel_t module_sel, input intc_sel_t slot_sel);
    return ^{module_sel, slot_sel};
  endfunction

endpackage

// File: rtl/intc_route_sequencer_if.sv
// Command, configuration and interconnect-control bundle of the route sequencer.
// master drives commands/config; slave is the sequencer side.
interface intc_route_sequencer_if;
  import intc_route_sequencer_pkg::*;

  logic        cfg_we;
  intc_addr_t  cfg_addr;
  intc_sel_t   cfg_module_sel;
  intc_sel_t   cfg_slot_sel;

  logic        cmd_valid;
  logic        cmd_ready;
  intc_addr_t  cmd_addr;
  intc_tag_t   cmd_tag;

  logic        flush;
  logic        flush_done;

  intc_sel_t   module_select;
  intc_sel_t   slot_select;
  logic        issue;
  logic        done_valid;
  intc_tag_t   done_tag;
  intc_count_t inflight;
  logic        cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_module_sel, cfg_slot_sel,
    output cmd_valid, cmd_addr, cmd_tag, flush,
    input  cmd_ready, flush_done, module_select, slot_select,
    input  issue, done_valid, done_tag, inflight, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_module_sel, cfg_slot_sel,
    input  cmd_valid, cmd_addr, cmd_tag, flush,
    output cmd_ready, flush_done, module_select, slot_select,
    output issue, done_valid, done_tag, inflight, cfg_err
  );

endinterface

// File: rtl/intc_route_sequencer_valid.sv
// Fixed-latency pipeline of {valid, tag} mirroring the interconnect data path.
// Tags are zeroed on entry for idle slots so the output tag is 0 whenever valid is 0.
module intc_valid_delay
  import intc_route_sequencer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  intc_tag_t in_tag,
  output logic      out_valid,
  output intc_tag_t out_tag
);

  genvar gi;
  generate
    for (gi = 0; gi < INTC_LATENCY; gi++) begin : g_stage
      logic      valid_reg;
      intc_tag_t tag_reg;
      logic      prev_valid;
      intc_tag_t prev_tag;

      if (gi == 0) begin : g_head
        assign prev_valid = in_valid;
        assign prev_tag   = in_valid ? in_tag : '0;
      end else begin : g_link
        assign prev_valid = g_stage[gi-1].valid_reg;
        assign prev_tag   = g_stage[gi-1].tag_reg;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
        end else begin
          valid_reg <= prev_valid;
          tag_reg   <= prev_tag;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[INTC_LATENCY-1].valid_reg;
  assign out_tag   = g_stage[INTC_LATENCY-1].tag_reg;

endmodule

// File: rtl/intc_route_sequencer.sv
// Route-table sequencer feeding the packed Benes interconnect select matrices.
// Define INTC_ROUTE_PARITY_EN to store and check an even-parity bit per table entry.
module intc_route_sequencer
  import intc_route_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  intc_route_sequencer_if.slave bus
);

  intc_sel_t       module_tab [CFG_DEPTH];
  intc_sel_t       slot_tab   [CFG_DEPTH];

  intc_seq_state_t state_reg;
  intc_count_t     inflight_reg;
  intc_count_t     inflight_next;
  logic            flush_done_reg;

  intc_sel_t       module_sel_reg;
  intc_sel_t       slot_sel_reg;
  logic            issue_reg;
  intc_tag_t       issue_tag_reg;

  logic            cmd_ready;
  logic            accept;
  logic            done_valid;
  intc_tag_t       done_tag;

  // Ready is forced low during reset even though the state already reads RUN.
  assign cmd_ready = !rst && (state_reg == RUN) && (inflight_reg < MAX_CNT) && !bus.flush;
  assign accept    = bus.cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CFG_DEPTH; i++) begin
        module_tab[i] <= '0;
        slot_tab[i]   <= '0;
      end
    end else if (bus.cfg_we) begin
      module_tab[bus.cfg_addr] <= bus.cfg_module_sel;
      slot_tab[bus.cfg_addr]   <= bus.cfg_slot_sel;
    end
  end

  // Table read happens before the write lands, so a same-cycle read sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      module_sel_reg <= '0;
      slot_sel_reg   <= '0;
      issue_reg      <= 1'b0;
      issue_tag_reg  <= '0;
    end else begin
      issue_reg <= accept;
      if (accept) begin
        module_sel_reg <= module_tab[bus.cmd_addr];
        slot_sel_reg   <= slot_tab[bus.cmd_addr];
        issue_tag_reg  <= bus.cmd_tag;
      end
    end
  end

  intc_valid_delay u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_reg),
    .in_tag    (issue_tag_reg),
    .out_valid (done_valid),
    .out_tag   (done_tag)
  );

  always_comb begin
    inflight_next = inflight_reg;
    if (accept && !done_valid) begin
      if (inflight_reg != MAX_CNT) begin
        inflight_next = inflight_reg + 1'b1;
      end
    end else if (!accept && done_valid) begin
      if (inflight_reg != '0) begin
        inflight_next = inflight_reg - 1'b1;
      end
    end
  end

  // DRAIN looks at the post-edge count so the flush pulse follows the last completion by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      inflight_reg   <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      inflight_reg   <= inflight_next;
      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (bus.flush) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_next == '0) begin
            state_reg      <= DONE;
            flush_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

`ifdef INTC_ROUTE_PARITY_EN
  logic [CFG_DEPTH-1:0] par_reg;
  logic                 cfg_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_reg <= '0;
    end else if (bus.cfg_we) begin
      par_reg[bus.cfg_addr] <= route_parity(bus.cfg_module_sel, bus.cfg_slot_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_reg <= 1'b0;
    end else if (accept &&
                 (route_parity(module_tab[bus.cmd_addr], slot_tab[bus.cmd_addr]) != par_reg[bus.cmd_addr])) begin
      cfg_err_reg <= 1'b1;
    end
  end

  assign bus.cfg_err = cfg_err_reg;
`else
  assign bus.cfg_err = 1'b0;
`endif

  assign bus.cmd_ready     = cmd_ready;
  assign bus.flush_done    = flush_done_reg;
  assign bus.module_select = module_sel_reg;
  assign bus.slot_select   = slot_sel_reg;
  assign bus.issue         = issue_reg;
  assign bus.done_valid    = done_valid;
  assign bus.done_tag      = done_tag;
  assign bus.inflight      = inflight_reg;

endmodule

// File: tb/tb_intc_route_sequencer.sv
// Directed self-checking bench for intc_route_sequencer (latency 11, 8 outstanding).
// The parity scenario is compiled in only when INTC_ROUTE_PARITY_EN is defined.
module tb_intc_route_sequencer;
  import intc_route_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  intc_route_sequencer_if bus ();

  intc_route_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input intc_addr_t addr, input intc_sel_t m, input intc_sel_t s);
    bus.cfg_we         = 1'b1;
    bus.cfg_addr       = addr;
    bus.cfg_module_sel = m;
    bus.cfg_slot_sel   = s;
    step;
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", bus.cmd_ready); end
    total++; if (bus.issue !== 1'b0) begin bad++; $display("FAIL rst_issue got=%0b want=0", bus.issue); end
    total++; if (bus.module_select !== '0) begin bad++; $display("FAIL rst_module_sel got=%h want=0", bus.module_select); end
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL rst_done_valid got=%0b want=0", bus.done_valid); end
    total++; if (bus.inflight !== '0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", bus.inflight); end
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%0b want=0", bus.flush_done); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%0b want=0", bus.cfg_err); end
    step;
    step;
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", bus.cmd_ready); end
    $display("test_reset complete");
  endtask

  task automatic test_route;
    intc_sel_t alt;
    intc_sel_t ones;
    int        early;
    alt  = {72{2'b10}};
    ones = '1;
    cfg_write(4'd3, alt, ones);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd3;
    bus.cmd_tag   = 4'd5;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t1_ready got=%0b want=1", bus.cmd_ready); end
    step;
    bus.cmd_valid = 1'b0;
    $display("cmd addr=3 tag=5 accepted");
    total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL t1_issue got=%0b want=1", bus.issue); end
    total++; if (bus.module_select !== alt) begin bad++; $display("FAIL t1_module_sel got=%h want=%h", bus.module_select, alt); end
    total++; if (bus.slot_select !== ones) begin bad++; $display("FAIL t1_slot_sel got=%h want=%h", bus.slot_select, ones); end
    total++; if (bus.inflight !== 4'd1) begin bad++; $display("FAIL t1_inflight got=%0d want=1", bus.inflight); end
    step;
    total++; if (bus.issue !== 1'b0) begin bad++; $display("FAIL t1_issue_pulse got=%0b want=0", bus.issue); end
    total++; if (bus.module_select !== alt) begin bad++; $display("FAIL t1_sel_hold got=%h want=%h", bus.module_select, alt); end
    early = 0;
    for (int i = 2; i <= 10; i++) begin
      step;
      if (bus.done_valid) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL t1_early_done got=%0d want=0", early); end
    step;
    total++; if (bus.done_valid !== 1'b1) begin bad++; $display("FAIL t1_done_valid got=%0b want=1", bus.done_valid); end
    total++; if (bus.done_tag !== 4'd5) begin bad++; $display("FAIL t1_done_tag got=%0d want=5", bus.done_tag); end
    step;
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%0b want=0", bus.done_valid); end
    total++; if (bus.done_tag !== 4'd0) begin bad++; $display("FAIL t1_idle_tag got=%0d want=0", bus.done_tag); end
    total++; if (bus.inflight !== 4'd0) begin bad++; $display("FAIL t1_inflight_end got=%0d want=0", bus.inflight); end
  endtask

  task automatic test_same_cycle_write;
    intc_sel_t am, as, bm, bs;
    am = {36{4'h3}};
    as = {36{4'hC}};
    bm = {36{4'h5}};
    bs = {36{4'hA}};
    cfg_write(4'd2, am, as);
    bus.cfg_we         = 1'b1;
    bus.cfg_addr       = 4'd2;
    bus.cfg_module_sel = bm;
    bus.cfg_slot_sel   = bs;
    bus.cmd_valid      = 1'b1;
    bus.cmd_addr       = 4'd2;
    bus.cmd_tag        = 4'd3;
    step;
    bus.cfg_we  = 1'b0;
    bus.cmd_tag = 4'd4;
    $display("cmd addr=2 tag=3 with concurrent write");
    total++; if (bus.module_select !== am) begin bad++; $display("FAIL t3_old_module got=%h want=%h", bus.module_select, am); end
    total++; if (bus.slot_select !== as) begin bad++; $display("FAIL t3_old_slot got=%h want=%h", bus.slot_select, as); end
    step;
    bus.cmd_valid = 1'b0;
    $display("cmd addr=2 tag=4");
    total++; if (bus.module_select !== bm) begin bad++; $display("FAIL t3_new_module got=%h want=%h", bus.module_select, bm); end
    total++; if (bus.slot_select !== bs) begin bad++; $display("FAIL t3_new_slot got=%h want=%h", bus.slot_select, bs); end
    for (int i = 0; i < 10; i++) step;
    total++; if (bus.done_tag !== 4'd3 || bus.done_valid !== 1'b1) begin bad++; $display("FAIL t3_done_first got=%0b/%0d want=1/3", bus.done_valid, bus.done_tag); end
    step;
    total++; if (bus.done_tag !== 4'd4 || bus.done_valid !== 1'b1) begin bad++; $display("FAIL t3_done_second got=%0b/%0d want=1/4", bus.done_valid, bus.done_tag); end
    step;
    total++; if (bus.inflight !== 4'd0) begin bad++; $display("FAIL t3_inflight got=%0d want=0", bus.inflight); end
  endtask

  task automatic test_back_to_back;
    int acc;
    acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd0;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_tag = 4'(c);
      if (c == 8) begin
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL t2_ready_full got=%0b want=0", bus.cmd_ready); end
        total++; if (bus.inflight !== 4'd8) begin bad++; $display("FAIL t2_inflight_full got=%0d want=8", bus.inflight); end
      end
      if (bus.cmd_ready) acc++;
      step;
    end
    $display("burst accepted=%0d", acc);
    total++; if (acc !== 8) begin bad++; $display("FAIL t2_accept_count got=%0d want=8", acc); end
    total++; if (bus.done_valid !== 1'b1 || bus.done_tag !== 4'd0) begin bad++; $display("FAIL t2_first_done got=%0b/%0d want=1/0", bus.done_valid, bus.done_tag); end
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL t2_ready_at_done got=%0b want=0", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    step;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t2_ready_back got=%0b want=1", bus.cmd_ready); end
    total++; if (bus.inflight !== 4'd7) begin bad++; $display("FAIL t2_inflight_dec got=%0d want=7", bus.inflight); end
    for (int k = 1; k < 8; k++) begin
      total++; if (bus.done_valid !== 1'b1 || bus.done_tag !== 4'(k)) begin bad++; $display("FAIL t2_done_order got=%0b/%0d want=1/%0d", bus.done_valid, bus.done_tag, k); end
      step;
    end
    total++; if (bus.inflight !== 4'd0 || bus.done_valid !== 1'b0) begin bad++; $display("FAIL t2_drained got=%0d/%0b want=0/0", bus.inflight, bus.done_valid); end
  endtask

  task automatic test_flush;
    int seen;
    int early_fd;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd3;
    for (int k = 0; k < 3; k++) begin
      bus.cmd_tag = 4'(7 + k);
      step;
      total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL t4_issue got=%0b want=1", bus.issue); end
    end
    bus.cmd_valid = 1'b0;
    bus.flush     = 1'b1;
    #1;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_flush got=%0b want=0", bus.cmd_ready); end
    step;
    bus.flush = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_drain got=%0b want=0", bus.cmd_ready); end
    seen     = 0;
    early_fd = 0;
    for (int n = 0; n < 30 && seen < 3; n++) begin
      step;
      if (bus.flush_done) early_fd++;
      if (bus.done_valid) seen++;
    end
    total++; if (seen !== 3) begin bad++; $display("FAIL t4_done_count got=%0d want=3", seen); end
    total++; if (early_fd !== 0) begin bad++; $display("FAIL t4_early_flush_done got=%0d want=0", early_fd); end
    step;
    $display("flush with 3 in flight");
    total++; if (bus.flush_done !== 1'b1) begin bad++; $display("FAIL t4_flush_done got=%0b want=1", bus.flush_done); end
    step;
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL t4_flush_pulse got=%0b want=0", bus.flush_done); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t4_ready_run got=%0b want=1", bus.cmd_ready); end
    bus.flush = 1'b1;
    step;
    bus.flush = 1'b0;
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL t4_empty_early got=%0b want=0", bus.flush_done); end
    step;
    $display("flush with 0 in flight");
    total++; if (bus.flush_done !== 1'b1) begin bad++; $display("FAIL t4_empty_flush_done got=%0b want=1", bus.flush_done); end
    step;
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL t4_empty_pulse got=%0b want=0", bus.flush_done); end
  endtask

`ifdef INTC_ROUTE_PARITY_EN
  task automatic test_parity;
    logic [CFG_DEPTH-1:0] p;
    cfg_write(4'd5, {36{4'h3}}, {36{4'hA}});
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL t6_err_clean got=%0b want=0", bus.cfg_err); end
    p = dut.par_reg;
    force dut.par_reg = p ^ 16'h0020;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd5;
    bus.cmd_tag   = 4'd6;
    step;
    bus.cmd_valid = 1'b0;
    release dut.par_reg;
    $display("cmd addr=5 tag=6 with corrupted parity");
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL t6_err_set got=%0b want=1", bus.cfg_err); end
    total++; if (bus.issue !== 1'b1) begin bad++; $display("FAIL t6_issue got=%0b want=1", bus.issue); end
    for (int i = 0; i < 10; i++) step;
    step;
    total++; if (bus.done_valid !== 1'b1 || bus.done_tag !== 4'd6) begin bad++; $display("FAIL t6_done got=%0b/%0d want=1/6", bus.done_valid, bus.done_tag); end
    step;
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL t6_err_sticky got=%0b want=1", bus.cfg_err); end
  endtask
`endif

  task automatic test_reset_midstream;
    int late;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      bus.cmd_tag = 4'(k);
      step;
    end
    bus.cmd_valid = 1'b0;
    step;
    step;
    total++; if (bus.inflight !== 4'd5) begin bad++; $display("FAIL t5_inflight_pre got=%0d want=5", bus.inflight); end
    rst = 1'b1;
    #1;
    $display("reset with 5 in flight");
    total++; if (bus.inflight !== 4'd0) begin bad++; $display("FAIL t5_inflight got=%0d want=0", bus.inflight); end
    total++; if (bus.module_select !== '0 || bus.slot_select !== '0) begin bad++; $display("FAIL t5_selects got=%h/%h want=0/0", bus.module_select, bus.slot_select); end
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL t5_ready got=%0b want=0", bus.cmd_ready); end
    total++; if (bus.issue !== 1'b0 || bus.done_valid !== 1'b0 || bus.done_tag !== '0) begin bad++; $display("FAIL t5_pipe got=%0b/%0b/%0d want=0/0/0", bus.issue, bus.done_valid, bus.done_tag); end
    total++; if (bus.cfg_err !== 1'b0 || bus.flush_done !== 1'b0) begin bad++; $display("FAIL t5_flags got=%0b/%0b want=0/0", bus.cfg_err, bus.flush_done); end
    step;
    step;
    rst = 1'b0;
    late = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (bus.done_valid) late++;
    end
    total++; if (late !== 0) begin bad++; $display("FAIL t5_late_done got=%0d want=0", late); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL t5_ready_after got=%0b want=1", bus.cmd_ready); end
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    rst                = 1'b1;
    bus.cfg_we         = 1'b0;
    bus.cfg_addr       = '0;
    bus.cfg_module_sel = '0;
    bus.cfg_slot_sel   = '0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_addr       = '0;
    bus.cmd_tag        = '0;
    bus.flush          = 1'b0;

    test_reset();
    test_route();
    test_same_cycle_write();
    test_back_to_back();
    test_flush();
`ifdef INTC_ROUTE_PARITY_EN
    test_parity();
`endif
    test_reset_midstream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
